// File: rtl/dino_pkg.sv
// Shared LittleDinosaur definitions: spawner FSM states, obstacle type codes
// and the random-batch geometry agreed with the random-number block.
package dino_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_LOAD,
      ST_GAP,
      ST_EMIT
   } state_t;

   localparam logic [1:0] OBS_SMALL0 = 2'd0;
   localparam logic [1:0] OBS_SMALL1 = 2'd1;
   localparam logic [1:0] OBS_LARGE  = 2'd2;
   localparam logic [1:0] OBS_BIRD   = 2'd3;

   localparam int unsigned DEF_NUM_W     = 4;
   localparam int unsigned DEF_NUM_COUNT = 4;

endpackage

// File: rtl/spawn_buffer.sv
// Register file holding one random batch, read sequentially from rd_ptr;
// peek_ptr gives a second read port for the entry after the current one.
module spawn_buffer
   import dino_pkg::*;
#(
   parameter int unsigned NUM_W     = DEF_NUM_W,
   parameter int unsigned NUM_COUNT = DEF_NUM_COUNT
)(
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    load,
   input  logic                                    pop,
   input  logic                                    flush,
   input  logic [NUM_W*NUM_COUNT-1:0]              data,
   input  logic [((NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1)-1:0] peek_ptr,
   output logic [((NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1)-1:0] rd_ptr,
   output logic [$clog2(NUM_COUNT + 1)-1:0]        avail,
   output logic                                    empty,
   output logic [NUM_W-1:0]                        head,
   output logic [NUM_W-1:0]                        peek
);

   localparam int unsigned PTR_W = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;
   localparam int unsigned CNT_W = $clog2(NUM_COUNT + 1);

   logic [NUM_W-1:0] mem [NUM_COUNT];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < NUM_COUNT; k++) mem[k] <= '0;
         rd_ptr <= '0;
         avail  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         avail  <= '0;
      end else if (load) begin
         for (int unsigned k = 0; k < NUM_COUNT; k++) mem[k] <= data[k*NUM_W +: NUM_W];
         rd_ptr <= '0;
         avail  <= CNT_W'(NUM_COUNT);
      end else if (pop && !empty) begin
         rd_ptr <= (rd_ptr == PTR_W'(NUM_COUNT - 1)) ? '0 : rd_ptr + PTR_W'(1);
         avail  <= avail - CNT_W'(1);
      end
   end

   assign empty = (avail == '0);
   assign head  = mem[rd_ptr];
   assign peek  = mem[peek_ptr];

endmodule

// File: rtl/obstacle_spawner.sv
// Turns buffered random values into tick-timed obstacle spawn events with a
// valid/ready handshake; refills the buffer from the random block when drained.
module obstacle_spawner
   import dino_pkg::*;
#(
   parameter int unsigned NUM_W     = DEF_NUM_W,
   parameter int unsigned NUM_COUNT = DEF_NUM_COUNT,
   parameter int unsigned MIN_GAP   = 8,
   parameter int unsigned GAP_W     = 8
)(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       tick,
   output logic                       rnd_start,
   input  logic [NUM_W*NUM_COUNT-1:0] randoms,
   output logic                       spawn_valid,
   input  logic                       spawn_ready,
   output logic [1:0]                 spawn_type,
   output logic [NUM_W-1:0]           spawn_value,
   output logic [15:0]                spawned_total
);

   localparam int unsigned PTR_W = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;
   localparam int unsigned CNT_W = $clog2(NUM_COUNT + 1);

   state_t           state;
   logic [GAP_W-1:0] gap_cnt;
   logic [PTR_W-1:0] rd_ptr, peek_ptr;
   logic [CNT_W-1:0] avail;
   logic             empty, handshake;
   logic [NUM_W-1:0] head, peek;

   function automatic logic [GAP_W-1:0] gap_of(input logic [NUM_W-1:0] v);
      return GAP_W'(MIN_GAP) + GAP_W'(v);
   endfunction

   assign handshake = (state == ST_EMIT) && spawn_valid && spawn_ready;
   assign peek_ptr  = (rd_ptr == PTR_W'(NUM_COUNT - 1)) ? '0 : rd_ptr + PTR_W'(1);

   spawn_buffer #(.NUM_W(NUM_W), .NUM_COUNT(NUM_COUNT)) u_buf (
      .clock    (clock),
      .reset    (reset),
      .load     (enable && (state == ST_LOAD)),
      .pop      (handshake),
      .flush    (!enable),
      .data     (randoms),
      .peek_ptr (peek_ptr),
      .rd_ptr   (rd_ptr),
      .avail    (avail),
      .empty    (empty),
      .head     (head),
      .peek     (peek)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         rnd_start     <= 1'b0;
         spawn_valid   <= 1'b0;
         spawn_type    <= '0;
         spawn_value   <= '0;
         spawned_total <= '0;
         gap_cnt       <= '0;
      end else begin
         rnd_start <= 1'b0;
         if (handshake && spawned_total != 16'hFFFF)
            spawned_total <= spawned_total + 16'd1;
         // A handshake coinciding with disable still counts; the event is then dropped.
         if (!enable) begin
            state       <= ST_IDLE;
            spawn_valid <= 1'b0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  state     <= ST_REQ;
                  rnd_start <= 1'b1;
               end
               ST_REQ:  state <= ST_LOAD;
               ST_LOAD: begin
                  gap_cnt <= gap_of(randoms[NUM_W-1:0]);
                  state   <= ST_GAP;
               end
               ST_GAP: begin
                  if (tick && !empty) begin
                     gap_cnt <= gap_cnt - GAP_W'(1);
                     if (gap_cnt == GAP_W'(1)) begin
                        state       <= ST_EMIT;
                        spawn_valid <= 1'b1;
                        spawn_type  <= head[1:0];
                        spawn_value <= head;
                     end
                  end
               end
               ST_EMIT: begin
                  if (handshake) begin
                     spawn_valid <= 1'b0;
                     if (avail == CNT_W'(1)) begin
                        state     <= ST_REQ;
                        rnd_start <= 1'b1;
                     end else begin
                        gap_cnt <= gap_of(peek);
                        state   <= ST_GAP;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed checks of obstacle_spawner: gap timing, types, refill, enable drop,
// asynchronous reset and total-count saturation.
module tb_obstacle_spawner;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        tick = 1'b0;
   logic        spawn_ready = 1'b0;
   logic [15:0] randoms = 16'h3210;
   logic        rnd_start, spawn_valid;
   logic [1:0]  spawn_type;
   logic [3:0]  spawn_value;
   logic [15:0] spawned_total;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   obstacle_spawner #(.NUM_W(4), .NUM_COUNT(4), .MIN_GAP(8), .GAP_W(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .tick          (tick),
      .rnd_start     (rnd_start),
      .randoms       (randoms),
      .spawn_valid   (spawn_valid),
      .spawn_ready   (spawn_ready),
      .spawn_type    (spawn_type),
      .spawn_value   (spawn_value),
      .spawned_total (spawned_total)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Called at the falling edge inside REQ; returns at the falling edge inside GAP.
   task automatic refill(input string tag);
      chk({tag, "_rnd_req"}, 32'(rnd_start), 32'd1);
      chk({tag, "_valid_req"}, 32'(spawn_valid), 32'd0);
      tick = 1'b1;
      @(negedge clock);
      chk({tag, "_rnd_load"}, 32'(rnd_start), 32'd0);
      @(negedge clock);
      tick = 1'b0;
   endtask

   task automatic gap_run(input string tag, input int exp_gap, input int exp_type, input int exp_val);
      int n = 0;
      while (!spawn_valid && n < 64) begin
         tick = 1'b1;
         @(negedge clock);
         tick = 1'b0;
         n++;
      end
      chk({tag, "_gap"}, 32'(n), 32'(exp_gap));
      chk({tag, "_valid"}, 32'(spawn_valid), 32'd1);
      chk({tag, "_type"}, 32'(spawn_type), 32'(exp_type));
      chk({tag, "_value"}, 32'(spawn_value), 32'(exp_val));
   endtask

   task automatic handshake(input string tag, input int exp_total);
      spawn_ready = 1'b1;
      @(negedge clock);
      spawn_ready = 1'b0;
      chk({tag, "_valid_after"}, 32'(spawn_valid), 32'd0);
      chk({tag, "_total"}, 32'(spawned_total), 32'(exp_total));
   endtask

   initial begin
      int gaps [4]  = '{15, 18, 11, 23};
      int types [4] = '{3, 2, 3, 3};
      int vals [4]  = '{7, 10, 3, 15};

      #1;
      chk("rst_rnd", 32'(rnd_start), 32'd0);
      chk("rst_valid", 32'(spawn_valid), 32'd0);
      chk("rst_type", 32'(spawn_type), 32'd0);
      chk("rst_value", 32'(spawn_value), 32'd0);
      chk("rst_total", 32'(spawned_total), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("idle_rnd", 32'(rnd_start), 32'd0);

      // Batch 3210: gaps 8..11, types 0..3; ticks in REQ/LOAD/EMIT ignored
      enable = 1'b1;
      @(negedge clock);
      refill("t1");
      gap_run("t1_e0", 8, 0, 0);
      tick = 1'b1;
      for (int i = 0; i < 3; i++) @(negedge clock);
      tick = 1'b0;
      chk("t1_emit_hold", 32'(spawn_valid), 32'd1);
      handshake("t1_h0", 1);
      gap_run("t1_e1", 9, 1, 1);
      handshake("t1_h1", 2);
      gap_run("t1_e2", 10, 2, 2);
      handshake("t1_h2", 3);
      gap_run("t1_e3", 11, 3, 3);
      randoms = 16'h0005;
      handshake("t1_h3", 4);

      // Batch 0005: gap 13 then stall with ready low for 10 cycles
      refill("t2");
      gap_run("t2_e0", 13, 1, 5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("t3_stall_valid", 32'(spawn_valid), 32'd1);
      end
      chk("t3_stall_type", 32'(spawn_type), 32'd1);
      chk("t3_stall_value", 32'(spawn_value), 32'd5);
      chk("t3_stall_total", 32'(spawned_total), 32'd4);
      handshake("t3_h", 5);
      for (int i = 1; i < 4; i++) begin
         gap_run("t2_ez", 8, 0, 0);
         if (i == 3) randoms = 16'hF3A7;
         handshake("t2_hz", 5 + i);
      end

      // Batch F3A7: types 3,2,3,3 gaps 15,18,11,23
      refill("t4");
      for (int i = 0; i < 4; i++) begin
         gap_run("t4_e", gaps[i], types[i], vals[i]);
         if (i == 3) randoms = 16'h0000;
         handshake("t4_h", 9 + i);
      end
      refill("t4_refill");

      // Enable dropped mid-GAP
      for (int i = 0; i < 4; i++) begin
         tick = 1'b1;
         @(negedge clock);
      end
      enable = 1'b0;
      @(negedge clock);
      chk("t5_gap_valid", 32'(spawn_valid), 32'd0);
      chk("t5_gap_rnd", 32'(rnd_start), 32'd0);
      @(negedge clock);
      tick = 1'b0;
      enable = 1'b1;
      @(negedge clock);
      refill("t5a");
      gap_run("t5a_e", 8, 0, 0);

      // Enable dropped mid-EMIT: event discarded, not counted
      enable = 1'b0;
      @(negedge clock);
      chk("t5_emit_valid", 32'(spawn_valid), 32'd0);
      chk("t5_emit_total", 32'(spawned_total), 32'd12);
      enable = 1'b1;
      @(negedge clock);
      refill("t5b");
      gap_run("t5b_e", 8, 0, 0);

      // Handshake coinciding with disable still counts
      spawn_ready = 1'b1;
      enable = 1'b0;
      @(negedge clock);
      spawn_ready = 1'b0;
      chk("t5c_valid", 32'(spawn_valid), 32'd0);
      chk("t5c_total", 32'(spawned_total), 32'd13);
      chk("t5c_rnd", 32'(rnd_start), 32'd0);
      randoms = 16'h000E;
      enable = 1'b1;
      @(negedge clock);
      refill("t5c");
      gap_run("t6_e", 22, 2, 14);

      // Asynchronous reset in EMIT, checked before the next rising edge
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(spawn_valid), 32'd0);
      chk("t6_rst_type", 32'(spawn_type), 32'd0);
      chk("t6_rst_value", 32'(spawn_value), 32'd0);
      chk("t6_rst_total", 32'(spawned_total), 32'd0);
      chk("t6_rst_rnd", 32'(rnd_start), 32'd0);
      enable = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      force dut.spawned_total = 16'hFFFE;
      @(negedge clock);
      release dut.spawned_total;
      @(negedge clock);
      chk("t6_preload", 32'(spawned_total), 32'hFFFE);
      randoms = 16'h0000;
      enable = 1'b1;
      @(negedge clock);
      refill("t6");
      for (int i = 0; i < 3; i++) begin
         gap_run("t6_sat_e", 8, 0, 0);
         handshake("t6_sat", 32'hFFFF);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
